// File: rtl/scale_row_sched_pkg.sv
// Shared types and constants for the vertical scaler row path.
// Row positions are unsigned fixed point with FRAC_BITS fractional bits.
package scale_row_sched_pkg;
    localparam int RW         = 11;
    localparam int YS_W       = 10;
    localparam int FRAC_BITS  = 8;
    localparam int RING_SLOTS = 4;
    localparam int SLOT_W     = $clog2(RING_SLOTS);
    localparam int PROD_W     = YS_W + RW;
    localparam int BASE_W     = PROD_W - FRAC_BITS;

    typedef enum logic [3:0] {
        S_IDLE,
        S_MUL,
        S_CHECK,
        S_FETCH,
        S_WAIT_F,
        S_RUN,
        S_WAIT_I,
        S_NEXT,
        S_FLUSH,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [RW-1:0]        top;
        logic [RW-1:0]        bot;
        logic [FRAC_BITS-1:0] frac;
    } row_pos_t;
endpackage

// File: rtl/scale_row_sched_pos_calc.sv
// Source row position for one destination row: registered dst_row * y_scale,
// then clamp to the last source row so the bottom tap never runs off the frame.
module scale_pos_calc
    import scale_row_sched_pkg::*;
#(
    parameter int SRC_H = 360
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load,
    input  logic [RW-1:0]   dst_row,
    input  logic [YS_W-1:0] y_scale,
    output row_pos_t        pos
);
    localparam logic [BASE_W-1:0] LAST = BASE_W'(SRC_H - 1);

    logic [PROD_W-1:0] prod;
    logic [BASE_W-1:0] base;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            prod <= '0;
        else if (load)
            prod <= PROD_W'(dst_row) * PROD_W'(y_scale);
    end

    assign base = prod[PROD_W-1:FRAC_BITS];

    always_comb begin
        pos = '0;
        if (base >= LAST) begin
            pos.top  = LAST[RW-1:0];
            pos.bot  = LAST[RW-1:0];
            pos.frac = '0;
        end else begin
            pos.top  = base[RW-1:0];
            pos.bot  = base[RW-1:0] + RW'(1);
            pos.frac = prod[FRAC_BITS-1:0];
        end
    end
endmodule

// File: rtl/scale_row_sched.sv
// Vertical scaler row scheduler: keeps the two interpolation rows resident in
// a 4-slot line ring, kicks the row engine, and drains the rest of the frame.
module scale_row_sched
    import scale_row_sched_pkg::*;
#(
    parameter int SRC_H = 360
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [YS_W-1:0]      y_scale,
    input  logic [RW-1:0]        dst_h,
    output logic                 fetch_req,
    input  logic                 fetch_done,
    output logic                 interp_start,
    input  logic                 interp_done,
    output logic [SLOT_W-1:0]    sel_top,
    output logic [SLOT_W-1:0]    sel_bot,
    output logic [FRAC_BITS-1:0] y_frac,
    output logic [RW-1:0]        dst_row,
    output logic                 busy,
    output logic                 frame_done
);
    state_t          state, nxt;
    logic [YS_W-1:0] ys_q;
    logic [RW-1:0]   dh_q;
    logic [RW:0]     loaded;
    logic [RW:0]     need;
    logic            from_flush;
    logic            last_row;
    logic            have_rows;
    logic            flush_more;
    row_pos_t        pos;

    scale_pos_calc #(.SRC_H(SRC_H)) u_pos (
        .clk     (clk),
        .rstn    (rstn),
        .load    (state == S_MUL),
        .dst_row (dst_row),
        .y_scale (ys_q),
        .pos     (pos)
    );

    assign need       = {1'b0, pos.bot} + (RW+1)'(1);
    assign have_rows  = (loaded >= need);
    assign last_row   = (dst_row == dh_q - RW'(1));
    assign flush_more = (loaded < (RW+1)'(SRC_H));
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt          = state;
        fetch_req    = 1'b0;
        interp_start = 1'b0;
        case (state)
            S_IDLE:   if (start) nxt = (dst_h == '0) ? S_DONE : S_MUL;
            S_MUL:    nxt = S_CHECK;
            S_CHECK:  nxt = have_rows ? S_RUN : S_FETCH;
            S_FETCH: begin
                fetch_req = 1'b1;
                nxt       = S_WAIT_F;
            end
            S_WAIT_F: if (fetch_done) nxt = from_flush ? S_FLUSH : S_CHECK;
            S_RUN: begin
                interp_start = 1'b1;
                nxt          = S_WAIT_I;
            end
            S_WAIT_I: if (interp_done) nxt = S_NEXT;
            S_NEXT:   nxt = last_row ? S_FLUSH : S_MUL;
            S_FLUSH: begin
                if (flush_more) begin
                    fetch_req = 1'b1;
                    nxt       = S_WAIT_F;
                end else begin
                    nxt = S_DONE;
                end
            end
            S_DONE:   nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    // frame_done is registered off DONE, so it trails the DONE state by a cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ys_q       <= '0;
            dh_q       <= '0;
            dst_row    <= '0;
            loaded     <= '0;
            from_flush <= 1'b0;
            sel_top    <= '0;
            sel_bot    <= '0;
            y_frac     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ys_q       <= y_scale;
                        dh_q       <= dst_h;
                        dst_row    <= '0;
                        loaded     <= '0;
                        from_flush <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (have_rows) begin
                        sel_top <= pos.top[SLOT_W-1:0];
                        sel_bot <= pos.bot[SLOT_W-1:0];
                        y_frac  <= pos.frac;
                    end
                end
                S_FETCH:  from_flush <= 1'b0;
                S_WAIT_F: if (fetch_done) loaded <= loaded + (RW+1)'(1);
                S_NEXT:   if (!last_row) dst_row <= dst_row + RW'(1);
                S_FLUSH:  from_flush <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule
